pdp8_io_bus: RTL and testbench

Parametrised PDP-8 I/O backplane between the CPU IOT path and up to 12 peripheral slots (TTY, RF08, and others). On each IOT it decodes the device code and sequences the IOP1/IOP2/IOP4 pulses to the addressed slot. It accumulates skip, clear-AC and read data, then returns them to the CPU with a done strobe. It also owns a per-slot interrupt-enable mask and a registered, priority-encoded interrupt request.

---
 rtl/pdp8_io_bus.sv | 192 +++++++++++++++++++
 tb/tb_pdp8_io_bus.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8_io_bus.sv
// rtl/pdp8_io_bus.sv - PDP-8 I/O backplane: IOT decode, IOP1/2/4 sequencing, interrupt mask and priority
// Ports:
//   clk, reset (async, active high)
//   CPU side:  iot, io_select[5:0], mb[11:0], io_data_in[11:0]
//              -> io_data_out[11:0], io_data_avail, io_skip, io_clear_ac, io_done, io_nodev,
//                 io_interrupt, io_int_id
//   Slot side: dev_select[NDEV-1:0], dev_iop[2:0]
//              <- dev_data_out[12*NDEV-1:0], dev_data_avail, dev_skip, dev_clear_ac, dev_interrupt
module pdp8_io_bus #(
    parameter int               NDEV      = 2,
    parameter logic [6*NDEV-1:0] DEV_CODES = {6'o03, 6'o04},
    parameter logic [5:0]       MASK_CODE = 6'o77,
    localparam int              IW        = (NDEV > 1) ? $clog2(NDEV) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iot,
    input  logic [5:0]           io_select,
    input  logic [11:0]          mb,
    input  logic [11:0]          io_data_in,
    output logic [11:0]          io_data_out,
    output logic                 io_data_avail,
    output logic                 io_skip,
    output logic                 io_clear_ac,
    output logic                 io_done,
    output logic                 io_nodev,
    output logic                 io_interrupt,
    output logic [IW-1:0]        io_int_id,
    output logic [NDEV-1:0]      dev_select,
    output logic [2:0]           dev_iop,
    input  logic [12*NDEV-1:0]   dev_data_out,
    input  logic [NDEV-1:0]      dev_data_avail,
    input  logic [NDEV-1:0]      dev_skip,
    input  logic [NDEV-1:0]      dev_clear_ac,
    input  logic [NDEV-1:0]      dev_interrupt
);

    typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P4, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              iot_q;
    logic [2:0]        op_q;
    logic [NDEV-1:0]   hit_q, hit_d;
    logic              is_mask_q;
    logic [NDEV-1:0]   mask_q;
    logic [NDEV-1:0]   pend;
    logic [IW-1:0]     int_id_d;
    logic [11:0]       data_acc;
    logic              avail_acc, skip_acc, clr_acc;
    logic              start, op_bit;
    logic [11:0]       slot_data;
    logic              slot_avail, slot_skip, slot_clr;
    logic              unused_bits;

    // Device code is taken from io_select and pulse enables from mb[2:0]; the rest of mb is not needed.
    assign unused_bits = ^{mb[11:3], io_data_in};

    assign start = (state_q == S_IDLE) && iot && !iot_q;
    assign pend  = dev_interrupt & mask_q;

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NDEV; i++) begin
            hit_d[i] = (io_select == DEV_CODES[6*i +: 6]);
        end
    end

    // Lowest-index pending slot wins; scan downward so the last assignment is the lowest index.
    always_comb begin
        int_id_d = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (pend[i]) int_id_d = IW'(i);
        end
    end

    // Response of the selected slot (hit_q is one-hot or empty); data only counts with avail.
    always_comb begin
        slot_data  = '0;
        slot_avail = 1'b0;
        slot_skip  = 1'b0;
        slot_clr   = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (hit_q[i]) begin
                slot_skip = slot_skip | dev_skip[i];
                slot_clr  = slot_clr  | dev_clear_ac[i];
                if (dev_data_avail[i]) begin
                    slot_data  = slot_data | dev_data_out[12*i +: 12];
                    slot_avail = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        op_bit        = 1'b0;
        dev_select    = '0;
        dev_iop       = 3'b000;
        io_done       = 1'b0;
        io_nodev      = 1'b0;
        io_data_out   = '0;
        io_data_avail = 1'b0;
        io_skip       = 1'b0;
        io_clear_ac   = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_P1;
            S_P1: begin
                state_d    = S_P2;
                op_bit     = op_q[0];
                dev_select = hit_q;
                dev_iop    = {2'b00, op_q[0] & (|hit_q)};
            end
            S_P2: begin
                state_d    = S_P4;
                op_bit     = op_q[1];
                dev_select = hit_q;
                dev_iop    = {1'b0, op_q[1] & (|hit_q), 1'b0};
            end
            S_P4: begin
                state_d    = S_DONE;
                op_bit     = op_q[2];
                dev_select = hit_q;
                dev_iop    = {op_q[2] & (|hit_q), 2'b00};
            end
            S_DONE: begin
                state_d       = S_IDLE;
                io_done       = 1'b1;
                io_nodev      = !(|hit_q) && !is_mask_q;
                io_data_out   = data_acc;
                io_data_avail = avail_acc;
                io_skip       = skip_acc;
                io_clear_ac   = clr_acc;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iot_q        <= 1'b0;
            op_q         <= 3'b000;
            hit_q        <= '0;
            is_mask_q    <= 1'b0;
            mask_q       <= '1;
            data_acc     <= '0;
            avail_acc    <= 1'b0;
            skip_acc     <= 1'b0;
            clr_acc      <= 1'b0;
            io_interrupt <= 1'b0;
            io_int_id    <= '0;
        end else begin
            iot_q        <= iot;
            io_interrupt <= |pend;
            io_int_id    <= int_id_d;
            if (start) begin
                op_q      <= mb[2:0];
                hit_q     <= hit_d;
                is_mask_q <= (io_select == MASK_CODE);
                data_acc  <= '0;
                avail_acc <= 1'b0;
                skip_acc  <= 1'b0;
                clr_acc   <= 1'b0;
            end else if (op_bit) begin
                if (is_mask_q) begin
                    // Mask register: IOP1 skips on a pending enabled request, IOP2 reads, IOP4 writes.
                    unique case (state_q)
                        S_P1: skip_acc <= skip_acc | (|pend);
                        S_P2: begin
                            data_acc  <= data_acc | 12'(mask_q);
                            avail_acc <= 1'b1;
                        end
                        S_P4: mask_q <= io_data_in[NDEV-1:0];
                        default: ;
                    endcase
                end else if (|hit_q) begin
                    skip_acc <= skip_acc | slot_skip;
                    clr_acc  <= clr_acc | slot_clr;
                    if (slot_avail) begin
                        data_acc  <= data_acc | slot_data;
                        avail_acc <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pdp8_io_bus.sv
// tb/tb_pdp8_io_bus.sv - self-checking bench for pdp8_io_bus
module tb_pdp8_io_bus;
    localparam int         NDEV  = 2;
    localparam logic [5:0] CODE0 = 6'o04;
    localparam logic [5:0] CODE1 = 6'o03;
    localparam logic [5:0] MCODE = 6'o77;

    logic              clk = 1'b0;
    logic              reset;
    logic              iot;
    logic [5:0]        io_select;
    logic [11:0]       mb;
    logic [11:0]       io_data_in;
    logic [11:0]       io_data_out;
    logic              io_data_avail, io_skip, io_clear_ac, io_done, io_nodev, io_interrupt;
    logic [0:0]        io_int_id;
    logic [NDEV-1:0]   dev_select;
    logic [2:0]        dev_iop;
    logic [12*NDEV-1:0] dev_data_out;
    logic [NDEV-1:0]   dev_data_avail, dev_skip, dev_clear_ac, dev_interrupt;

    always #5 clk = ~clk;

    pdp8_io_bus #(.NDEV(NDEV), .DEV_CODES({CODE1, CODE0}), .MASK_CODE(MCODE)) dut (
        .clk(clk), .reset(reset), .iot(iot), .io_select(io_select), .mb(mb),
        .io_data_in(io_data_in), .io_data_out(io_data_out), .io_data_avail(io_data_avail),
        .io_skip(io_skip), .io_clear_ac(io_clear_ac), .io_done(io_done), .io_nodev(io_nodev),
        .io_interrupt(io_interrupt), .io_int_id(io_int_id), .dev_select(dev_select),
        .dev_iop(dev_iop), .dev_data_out(dev_data_out), .dev_data_avail(dev_data_avail),
        .dev_skip(dev_skip), .dev_clear_ac(dev_clear_ac), .dev_interrupt(dev_interrupt)
    );

    // Per-slot, per-pulse response configuration (pulse index 0=IOP1, 1=IOP2, 2=IOP4).
    logic        cfg_skip [NDEV][3];
    logic        cfg_clr  [NDEV][3];
    logic        cfg_av   [NDEV][3];
    logic [11:0] cfg_data [NDEV][3];

    // Peripheral slots: respond combinationally while selected and pulsed.
    always_comb begin
        dev_data_out   = '0;
        dev_data_avail = '0;
        dev_skip       = '0;
        dev_clear_ac   = '0;
        for (int i = 0; i < NDEV; i++) begin
            for (int p = 0; p < 3; p++) begin
                if (dev_select[i] && dev_iop[p]) begin
                    dev_skip[i]       = dev_skip[i] | cfg_skip[i][p];
                    dev_clear_ac[i]   = dev_clear_ac[i] | cfg_clr[i][p];
                    dev_data_avail[i] = dev_data_avail[i] | cfg_av[i][p];
                    dev_data_out[12*i +: 12] = dev_data_out[12*i +: 12] | cfg_data[i][p];
                end
            end
        end
    end

    typedef struct {
        logic [5:0]  sel;
        logic [2:0]  op;
        logic [11:0] ac;
        logic [8:0]  iop;   // {P4,P2,P1} dev_iop
        logic [5:0]  dsel;  // {P4,P2,P1} dev_select
        logic [11:0] data;
        logic        av, sk, cl, nd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  r_iop;
    logic [5:0]  r_sel;
    logic [11:0] r_data;
    logic        r_av, r_sk, r_cl, r_nd, r_done, r_early, r_after;
    logic [0:0]  r_id_done;
    logic [1:0]  mask_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_iot(input logic [5:0] sel, input logic [2:0] op, input logic [11:0] ac);
        @(negedge clk);
        io_select  = sel;
        mb         = {3'b000, sel, op};
        io_data_in = ac;
        iot        = 1'b1;
        r_early    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) begin
                r_iop[3*k +: 3] = dev_iop;
                r_sel[2*k +: 2] = dev_select;
                if (io_done || io_nodev || io_skip || io_clear_ac || io_data_avail || io_data_out != 0)
                    r_early = 1'b1;
            end else begin
                r_done    = io_done;
                r_nd      = io_nodev;
                r_data    = io_data_out;
                r_av      = io_data_avail;
                r_sk      = io_skip;
                r_cl      = io_clear_ac;
                r_id_done = io_int_id;
                iot       = 1'b0;
            end
        end
        @(negedge clk);
        r_after = io_done;
    endtask

    task automatic cmp_iot(input string tag, input vec_t e);
        chk({tag, ".iop"},   32'(r_iop),   32'(e.iop));
        chk({tag, ".dsel"},  32'(r_sel),   32'(e.dsel));
        chk({tag, ".early"}, 32'(r_early), 32'd0);
        chk({tag, ".done"},  32'(r_done),  32'd1);
        chk({tag, ".after"}, 32'(r_after), 32'd0);
        chk({tag, ".data"},  32'(r_data),  32'(e.data));
        chk({tag, ".avail"}, 32'(r_av),    32'(e.av));
        chk({tag, ".skip"},  32'(r_sk),    32'(e.sk));
        chk({tag, ".clr"},   32'(r_cl),    32'(e.cl));
        chk({tag, ".nodev"}, 32'(r_nd),    32'(e.nd));
    endtask

    // Reference: walk the three pulses, apply the addressed target's rules, report the new mask.
    task automatic model(input logic [5:0] sel, input logic [2:0] op, input logic [11:0] ac,
                         output vec_t e, output logic [1:0] nm);
        int slot;
        slot = -1;
        if (sel == CODE0) slot = 0;
        if (sel == CODE1) slot = 1;
        e = '{sel: sel, op: op, ac: ac, iop: 9'd0, dsel: 6'd0, data: 12'd0,
              av: 1'b0, sk: 1'b0, cl: 1'b0, nd: 1'b0};
        nm = mask_m;
        for (int p = 0; p < 3; p++) begin
            if (slot >= 0) begin
                e.dsel[2*p +: 2] = (slot == 0) ? 2'b01 : 2'b10;
                if (op[p]) begin
                    e.iop[3*p +: 3] = 3'b001 << p;
                    e.sk = e.sk | cfg_skip[slot][p];
                    e.cl = e.cl | cfg_clr[slot][p];
                    if (cfg_av[slot][p]) begin
                        e.data = e.data | cfg_data[slot][p];
                        e.av   = 1'b1;
                    end
                end
            end else if (sel == MCODE && op[p]) begin
                if (p == 0) e.sk = e.sk | ((dev_interrupt & mask_m) != 0);
                if (p == 1) begin
                    e.data = e.data | {10'd0, mask_m};
                    e.av   = 1'b1;
                end
                if (p == 2) nm = ac[1:0];
            end
        end
        e.nd = (slot < 0) && (sel != MCODE);
    endtask

    vec_t tbl[8];
    vec_t e;
    logic [1:0] nm;
    logic [1:0] pend_m;
    int cnt;

    initial begin
        reset = 1'b1; iot = 1'b0; io_select = '0; mb = '0; io_data_in = '0; dev_interrupt = '0;
        for (int i = 0; i < NDEV; i++)
            for (int p = 0; p < 3; p++) begin
                cfg_skip[i][p] = 1'b0; cfg_clr[i][p] = 1'b0;
                cfg_av[i][p] = 1'b0; cfg_data[i][p] = '0;
            end
        mask_m = 2'b11;
        repeat (3) @(negedge clk);
        chk("rst.done", 32'(io_done), 0);
        chk("rst.nodev", 32'(io_nodev), 0);
        chk("rst.int", 32'(io_interrupt), 0);
        chk("rst.id", 32'(io_int_id), 0);
        chk("rst.dsel", 32'(dev_select), 0);
        chk("rst.iop", 32'(dev_iop), 0);
        chk("rst.data", 32'(io_data_out), 0);
        reset = 1'b0;
        @(negedge clk);

        // Table: slot1 (03) returns 0301 on IOP2; slot0 (04) skips on IOP1, clears AC and
        // returns 0055 on IOP4, drives 7777 without avail on IOP2.
        cfg_av[1][1] = 1'b1; cfg_data[1][1] = 12'o0301;
        cfg_skip[0][0] = 1'b1;
        cfg_clr[0][2] = 1'b1; cfg_av[0][2] = 1'b1; cfg_data[0][2] = 12'o0055;
        cfg_data[0][1] = 12'o7777;
        tbl[0] = '{sel: 6'o03, op: 3'b110, ac: 12'o0, iop: 9'b100_010_000, dsel: 6'b10_10_10,
                   data: 12'o0301, av: 1, sk: 0, cl: 0, nd: 0};
        tbl[1] = '{sel: 6'o04, op: 3'b001, ac: 12'o0, iop: 9'b000_000_001, dsel: 6'b01_01_01,
                   data: 12'o0, av: 0, sk: 1, cl: 0, nd: 0};
        tbl[2] = '{sel: 6'o04, op: 3'b000, ac: 12'o0, iop: 9'b000_000_000, dsel: 6'b01_01_01,
                   data: 12'o0, av: 0, sk: 0, cl: 0, nd: 0};
        tbl[3] = '{sel: 6'o04, op: 3'b111, ac: 12'o0, iop: 9'b100_010_001, dsel: 6'b01_01_01,
                   data: 12'o0055, av: 1, sk: 1, cl: 1, nd: 0};
        tbl[4] = '{sel: 6'o45, op: 3'b111, ac: 12'o7777, iop: 9'b0, dsel: 6'b0,
                   data: 12'o0, av: 0, sk: 0, cl: 0, nd: 1};
        tbl[5] = '{sel: 6'o77, op: 3'b010, ac: 12'o0, iop: 9'b0, dsel: 6'b0,
                   data: 12'o0003, av: 1, sk: 0, cl: 0, nd: 0};
        tbl[6] = '{sel: 6'o04, op: 3'b010, ac: 12'o0, iop: 9'b000_010_000, dsel: 6'b01_01_01,
                   data: 12'o0, av: 0, sk: 0, cl: 0, nd: 0};
        tbl[7] = '{sel: 6'o03, op: 3'b001, ac: 12'o0, iop: 9'b000_000_001, dsel: 6'b10_10_10,
                   data: 12'o0, av: 0, sk: 0, cl: 0, nd: 0};
        for (int i = 0; i < 8; i++) begin
            run_iot(tbl[i].sel, tbl[i].op, tbl[i].ac);
            cmp_iot($sformatf("tbl%0d", i), tbl[i]);
        end

        // Interrupt priority, mask write latency, mask read-back.
        dev_interrupt = 2'b11;
        repeat (2) @(negedge clk);
        chk("irq.int", 32'(io_interrupt), 1);
        chk("irq.id", 32'(io_int_id), 0);
        run_iot(6'o77, 3'b100, 12'o0002);
        cmp_iot("mwr", '{sel: 6'o77, op: 3'b100, ac: 12'o2, iop: 9'b0, dsel: 6'b0,
                         data: 12'o0, av: 0, sk: 0, cl: 0, nd: 0});
        chk("mwr.id_at_done", 32'(r_id_done), 0);
        chk("mwr.id_after", 32'(io_int_id), 1);
        chk("mwr.int_after", 32'(io_interrupt), 1);
        run_iot(6'o77, 3'b010, 12'o0);
        cmp_iot("mrd", '{sel: 6'o77, op: 3'b010, ac: 12'o0, iop: 9'b0, dsel: 6'b0,
                         data: 12'o0002, av: 1, sk: 0, cl: 0, nd: 0});

        // iot held high: exactly one sequence.
        @(negedge clk);
        io_select = 6'o04; mb = {3'b000, 6'o04, 3'b001}; iot = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (io_done) cnt++;
            if (i == 9) iot = 1'b0;
        end
        chk("held.ndone", 32'(cnt), 1);

        // Masked-pending skip via the mask register's IOP1.
        run_iot(6'o77, 3'b100, 12'o0001);
        dev_interrupt = 2'b10;
        run_iot(6'o77, 3'b001, 12'o0);
        cmp_iot("mskip0", '{sel: 6'o77, op: 3'b001, ac: 12'o0, iop: 9'b0, dsel: 6'b0,
                            data: 12'o0, av: 0, sk: 0, cl: 0, nd: 0});
        dev_interrupt = 2'b01;
        run_iot(6'o77, 3'b001, 12'o0);
        cmp_iot("mskip1", '{sel: 6'o77, op: 3'b001, ac: 12'o0, iop: 9'b0, dsel: 6'b0,
                            data: 12'o0, av: 0, sk: 1, cl: 0, nd: 0});

        // Reset during P2: immediate idle outputs, no done, mask back to all ones.
        @(negedge clk);
        io_select = 6'o03; mb = {3'b000, 6'o03, 3'b110}; iot = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rp2.iop_pre", 32'(dev_iop), 32'b010);
        reset = 1'b1;
        iot = 1'b0;
        #1;
        chk("rp2.iop", 32'(dev_iop), 0);
        chk("rp2.dsel", 32'(dev_select), 0);
        chk("rp2.done", 32'(io_done), 0);
        chk("rp2.int", 32'(io_interrupt), 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (io_done) cnt++;
        end
        chk("rp2.ndone", 32'(cnt), 0);
        mask_m = 2'b11;
        run_iot(6'o77, 3'b010, 12'o0);
        cmp_iot("rp2.mask", '{sel: 6'o77, op: 3'b010, ac: 12'o0, iop: 9'b0, dsel: 6'b0,
                              data: 12'o0003, av: 1, sk: 0, cl: 0, nd: 0});

        // Randomized IOTs against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [5:0]  rs;
            logic [2:0]  ro;
            logic [11:0] ra;
            for (int i = 0; i < NDEV; i++)
                for (int p = 0; p < 3; p++) begin
                    cfg_skip[i][p] = 1'($urandom);
                    cfg_clr[i][p]  = 1'($urandom);
                    cfg_av[i][p]   = 1'($urandom);
                    cfg_data[i][p] = 12'($urandom);
                end
            dev_interrupt = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: rs = CODE0;
                1: rs = CODE1;
                2: rs = MCODE;
                default: rs = 6'($urandom);
            endcase
            ro = 3'($urandom);
            ra = 12'($urandom);
            model(rs, ro, ra, e, nm);
            run_iot(rs, ro, ra);
            cmp_iot($sformatf("rnd%0d", n), e);
            mask_m = nm;
            pend_m = dev_interrupt & mask_m;
            chk($sformatf("rnd%0d.int", n), 32'(io_interrupt), 32'(pend_m != 0));
            chk($sformatf("rnd%0d.id", n), 32'(io_int_id), (pend_m[0] || !pend_m[1]) ? 0 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
